// File: rtl/instr_encoder_if.sv
// Shared RV32 field types plus the field-bundle / instruction-memory bus of the encoder.
// Both sides use valid/ready handshakes; the slave modport is the encoder's view.
package instr_encoder_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    LUI     = 3'd0,
    OP_IMM  = 3'd1,
    OP      = 3'd2,
    LOAD    = 3'd3,
    STORE   = 3'd4,
    UNKNOWN = 3'd5
  } opcode_t;

  typedef logic [4:0] rv_reg_t;
endpackage

interface instr_encoder_if
  import instr_encoder_pkg::*;
  ;
  logic            in_valid;
  logic            in_ready;
  opcode_t         opcode;
  rv_reg_t         rs1;
  rv_reg_t         rs2;
  rv_reg_t         rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] instr_bits;
  logic [XLEN-1:0] wr_addr;
  logic            err;
  logic [15:0]     emit_count;
  logic [15:0]     err_count;

  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr_bits, wr_addr, err, emit_count, err_count
  );

  modport master (
    output in_valid, opcode, rs1, rs2, rd, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr_bits, wr_addr, err, emit_count, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32 field-bundle encoder: one-cycle latency into a 2-entry skid; illegal bundles are dropped with an err pulse.
// Backpressure: in_ready is registered (low only when both entries are full), never combinational from out_ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset_n,
  instr_encoder_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [1:0]      state_q, state_d;
  logic [ILEN-1:0] main_instr_q, main_instr_d;
  logic [XLEN-1:0] main_addr_q, main_addr_d;
  logic [ILEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_addr_q, skid_addr_d;
  logic [XLEN-1:0] next_addr_q, next_addr_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [15:0]     emit_cnt_q, emit_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic [ILEN-1:0] enc;
  logic            bad;
  logic            is_shift;
  logic            imm12_ok;
  logic            out_valid;
  logic            accept;
  logic            legal;
  logic            xfer;

  assign is_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
  // A 12-bit signed immediate fits when bits [31:11] are a pure sign extension.
  assign imm12_ok = (&bus.imm[31:11]) || !(|bus.imm[31:11]);

  always_comb begin
    enc = '0;
    bad = 1'b0;
    case (bus.opcode)
      LUI: begin
        enc = {bus.imm[31:12], bus.rd, OPC_LUI};
        bad = |bus.imm[11:0];
      end
      OP: begin
        enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OPC_OP};
      end
      OP_IMM: begin
        if (is_shift) begin
          enc = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, OPC_OP_IMM};
          bad = |bus.imm[31:5];
        end else begin
          enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OPC_OP_IMM};
          bad = !imm12_ok;
        end
      end
      LOAD: begin
        enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OPC_LOAD};
        bad = !imm12_ok;
      end
      STORE: begin
        enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OPC_STORE};
        bad = !imm12_ok;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid && ready_q;
  assign legal     = accept && !bad;
  assign xfer      = out_valid && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_addr_d  = main_addr_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    next_addr_d  = next_addr_q;
    err_d        = accept && bad;
    emit_cnt_d   = emit_cnt_q;
    err_cnt_d    = err_cnt_q;

    // Addresses are handed out at encode time, so rejects never consume one.
    if (legal) begin
      next_addr_d = next_addr_q + 32'd4;
    end
    if (accept && bad && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if (xfer && (emit_cnt_q != 16'hFFFF)) begin
      emit_cnt_d = emit_cnt_q + 16'd1;
    end

    case (state_q)
      ST_EMPTY: begin
        if (legal) begin
          main_instr_d = enc;
          main_addr_d  = next_addr_q;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (legal && xfer) begin
          main_instr_d = enc;
          main_addr_d  = next_addr_q;
        end else if (legal) begin
          skid_instr_d = enc;
          skid_addr_d  = next_addr_q;
          state_d      = ST_TWO;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          main_instr_d = skid_instr_q;
          main_addr_d  = skid_addr_q;
          state_d      = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= '0;
      main_addr_q  <= '0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      next_addr_q  <= BASE_ADDR;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      emit_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_addr_q  <= main_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      next_addr_q  <= next_addr_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      emit_cnt_q   <= emit_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = out_valid;
  assign bus.instr_bits = out_valid ? main_instr_q : '0;
  assign bus.wr_addr    = main_addr_q;
  assign bus.err        = err_q;
  assign bus.emit_count = emit_cnt_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus a randomized run scored against an arithmetic encoding model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus0 ();
  instr_encoder_if bus1 ();

  // The second instance sees the same stimulus but starts near the top of the address space.
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.opcode    = bus0.opcode;
  assign bus1.rs1       = bus0.rs1;
  assign bus1.rs2       = bus0.rs2;
  assign bus1.rd        = bus0.rd;
  assign bus1.funct3    = bus0.funct3;
  assign bus1.funct7    = bus0.funct7;
  assign bus1.imm       = bus0.imm;
  assign bus1.out_ready = bus0.out_ready;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  typedef struct {
    opcode_t     op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    logic [31:0] bits;
    logic [31:0] addr;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bundle_t mk(opcode_t op, int rd, int rs1, int rs2, int f3, int f7, logic [31:0] imm);
    bundle_t b;
    b.op = op; b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
    b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = imm;
    return b;
  endfunction

  // Reference: {legal, word} from the instruction-format rules, using plain arithmetic.
  function automatic logic [32:0] ref_encode(bundle_t b);
    logic [31:0] w;
    logic [31:0] core;
    logic        ok;
    longint      s;
    s    = longint'($signed(b.imm));
    core = (32'(b.rs1) << 15) | (32'(b.f3) << 12) | (32'(b.rd) << 7);
    w    = 32'd0;
    ok   = 1'b0;
    case (b.op)
      LUI: begin
        ok = (b.imm % 4096) == 0;
        w  = b.imm + (32'(b.rd) << 7) + 32'h37;
      end
      OP: begin
        ok = 1'b1;
        w  = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | core | 32'h33;
      end
      OP_IMM: begin
        if (b.f3 == 3'd1 || b.f3 == 3'd5) begin
          ok = b.imm < 32;
          w  = (32'(b.f7) << 25) | ((b.imm % 32) << 20) | core | 32'h13;
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = ((b.imm % 4096) << 20) | core | 32'h13;
        end
      end
      LOAD: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((b.imm % 4096) << 20) | core | 32'h03;
      end
      STORE: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((b.imm / 32) % 128) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
           | (32'(b.f3) << 12) | ((b.imm % 32) << 7) | 32'h23;
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int      k;
    b.op  = opcode_t'(3'($urandom_range(0, 5)));
    b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom); b.f7  = 7'($urandom);
    k = $urandom_range(0, 9);
    if (k <= 4)      b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
    else if (k == 5) b.imm = 32'($urandom_range(2040, 2060));
    else if (k == 6) b.imm = 32'($urandom_range(0, 40));
    else if (k == 7) b.imm = $urandom & 32'hFFFF_F000;
    else             b.imm = $urandom;
    return b;
  endfunction

  task automatic drive(input logic v, input bundle_t b);
    bus0.in_valid = v;
    bus0.opcode   = b.op;
    bus0.rd       = b.rd;
    bus0.rs1      = b.rs1;
    bus0.rs2      = b.rs2;
    bus0.funct3   = b.f3;
    bus0.funct7   = b.f7;
    bus0.imm      = b.imm;
  endtask

  task automatic idle();
    drive(1'b0, mk(OP, 0, 0, 0, 0, 0, 32'h0));
  endtask

  // Returns at a falling edge with the encoders ready and inputs idle.
  task automatic apply_reset();
    idle();
    bus0.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    bus0.out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    n_tests++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus0.out_valid); end
    n_tests++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", bus0.in_ready); end
    n_tests++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", bus0.err); end
    n_tests++; if (bus0.instr_bits !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", bus0.instr_bits); end
    n_tests++; if (bus0.emit_count !== 16'h0 || bus0.err_count !== 16'h0) begin
      n_fail++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", bus0.emit_count, bus0.err_count); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", bus0.in_ready); end
    n_tests++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid got=%b exp=0", bus0.out_valid); end
  endtask

  task automatic test_addi();
    apply_reset();
    bus0.out_ready = 1'b1;
    drive(1'b1, mk(OP_IMM, 1, 2, 0, 0, 0, 32'hFFFF_FFFF));
    @(negedge clk);
    idle();
    n_tests++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", bus0.out_valid); end
    n_tests++; if (bus0.instr_bits !== 32'hFFF1_0093) begin n_fail++; $display("FAIL addi_bits got=%h exp=fff10093", bus0.instr_bits); end
    n_tests++; if (bus0.wr_addr !== 32'h0) begin n_fail++; $display("FAIL addi_addr got=%h exp=00000000", bus0.wr_addr); end
    @(negedge clk);
    n_tests++; if (bus0.out_valid !== 1'b0 || bus0.instr_bits !== 32'h0) begin
      n_fail++; $display("FAIL addi_drained got=%b/%h exp=0/00000000", bus0.out_valid, bus0.instr_bits); end
    n_tests++; if (bus0.emit_count !== 16'd1) begin n_fail++; $display("FAIL addi_emit got=%0d exp=1", bus0.emit_count); end
  endtask

  task automatic test_store_lui();
    apply_reset();
    bus0.out_ready = 1'b1;
    drive(1'b1, mk(STORE, 0, 2, 5, 2, 0, 32'd8));
    @(negedge clk);
    drive(1'b1, mk(LUI, 3, 0, 0, 0, 0, 32'h1234_5000));
    n_tests++; if (bus0.instr_bits !== 32'h0051_2423 || bus0.wr_addr !== 32'h0) begin
      n_fail++; $display("FAIL sw_word got=%h@%h exp=00512423@00000000", bus0.instr_bits, bus0.wr_addr); end
    @(negedge clk);
    idle();
    n_tests++; if (bus0.instr_bits !== 32'h1234_51B7 || bus0.wr_addr !== 32'h4) begin
      n_fail++; $display("FAIL lui_word got=%h@%h exp=123451b7@00000004", bus0.instr_bits, bus0.wr_addr); end
    @(negedge clk);
    n_tests++; if (bus0.emit_count !== 16'd2) begin n_fail++; $display("FAIL sw_lui_emit got=%0d exp=2", bus0.emit_count); end
  endtask

  task automatic test_reject();
    apply_reset();
    bus0.out_ready = 1'b1;
    drive(1'b1, mk(OP_IMM, 1, 2, 0, 0, 0, 32'h0000_0800));
    @(negedge clk);
    drive(1'b1, mk(OP_IMM, 1, 2, 0, 0, 0, 32'hFFFF_FFFF));
    n_tests++; if (bus0.err !== 1'b1) begin n_fail++; $display("FAIL rej_err got=%b exp=1", bus0.err); end
    n_tests++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rej_no_output got=%b exp=0", bus0.out_valid); end
    n_tests++; if (bus0.err_count !== 16'd1) begin n_fail++; $display("FAIL rej_err_count got=%0d exp=1", bus0.err_count); end
    @(negedge clk);
    idle();
    n_tests++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL rej_err_pulse got=%b exp=0", bus0.err); end
    n_tests++; if (bus0.out_valid !== 1'b1 || bus0.wr_addr !== 32'h0 || bus0.instr_bits !== 32'hFFF1_0093) begin
      n_fail++; $display("FAIL rej_next_legal got=%b %h@%h exp=1 fff10093@00000000", bus0.out_valid, bus0.instr_bits, bus0.wr_addr); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bundle_t     b[3];
    logic [32:0] e[3];
    apply_reset();
    b[0] = mk(OP, 4, 5, 6, 0, 7'h20, 32'h0);
    b[1] = mk(OP_IMM, 7, 8, 0, 4, 0, 32'h0000_0123);
    b[2] = mk(LOAD, 9, 10, 0, 2, 0, 32'hFFFF_FFF0);
    for (int i = 0; i < 3; i++) e[i] = ref_encode(b[i]);
    bus0.out_ready = 1'b0;
    drive(1'b1, b[0]);
    @(negedge clk);
    drive(1'b1, b[1]);
    @(negedge clk);
    drive(1'b1, b[2]);
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low cyc=%0d got=%b exp=0", c, bus0.in_ready); end
      n_tests++; if (bus0.instr_bits !== e[0][31:0] || bus0.wr_addr !== 32'h0) begin
        n_fail++; $display("FAIL bp_stable cyc=%0d got=%h@%h exp=%h@00000000", c, bus0.instr_bits, bus0.wr_addr, e[0][31:0]); end
      @(negedge clk);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.instr_bits !== e[1][31:0] || bus0.wr_addr !== 32'h4) begin
      n_fail++; $display("FAIL bp_second got=%h@%h exp=%h@00000004", bus0.instr_bits, bus0.wr_addr, e[1][31:0]); end
    @(negedge clk);
    idle();
    n_tests++; if (bus0.instr_bits !== e[2][31:0] || bus0.wr_addr !== 32'h8) begin
      n_fail++; $display("FAIL bp_third got=%h@%h exp=%h@00000008", bus0.instr_bits, bus0.wr_addr, e[2][31:0]); end
    @(negedge clk);
    n_tests++; if (bus0.out_valid !== 1'b0 || bus0.emit_count !== 16'd3) begin
      n_fail++; $display("FAIL bp_done got=%b/%0d exp=0/3", bus0.out_valid, bus0.emit_count); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr[3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
    apply_reset();
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(OP_IMM, i + 1, 0, 0, 0, 0, 32'(i)));
      @(negedge clk);
      n_tests++; if (bus1.out_valid !== 1'b1 || bus1.wr_addr !== exp_addr[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d got=%b@%h exp=1@%h", i, bus1.out_valid, bus1.wr_addr, exp_addr[i]); end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_in_two();
    logic [32:0] e3;
    apply_reset();
    bus0.out_ready = 1'b1;
    drive(1'b1, mk(LOAD, 1, 1, 0, 2, 0, 32'h0000_1000));
    @(negedge clk);
    drive(1'b1, mk(OP, 1, 2, 3, 0, 0, 32'h0));
    @(negedge clk);
    idle();
    @(negedge clk);
    bus0.out_ready = 1'b0;
    drive(1'b1, mk(OP, 4, 5, 6, 7, 0, 32'h0));
    @(negedge clk);
    drive(1'b1, mk(OP, 8, 9, 10, 1, 0, 32'h0));
    @(negedge clk);
    idle();
    n_tests++; if (bus0.in_ready !== 1'b0 || bus0.emit_count !== 16'd1 || bus0.err_count !== 16'd1) begin
      n_fail++; $display("FAIL r2_setup got=%b/%0d/%0d exp=0/1/1", bus0.in_ready, bus0.emit_count, bus0.err_count); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (bus0.out_valid !== 1'b0 || bus0.instr_bits !== 32'h0) begin
      n_fail++; $display("FAIL r2_valid_drop got=%b/%h exp=0/00000000", bus0.out_valid, bus0.instr_bits); end
    n_tests++; if (bus0.emit_count !== 16'd0 || bus0.err_count !== 16'd0) begin
      n_fail++; $display("FAIL r2_counts got=%0d/%0d exp=0/0", bus0.emit_count, bus0.err_count); end
    @(negedge clk);
    reset_n = 1'b1;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL r2_release got=%b/%b exp=1/0", bus0.in_ready, bus0.out_valid); end
    drive(1'b1, mk(OP_IMM, 3, 4, 0, 6, 0, 32'h0000_0055));
    e3 = ref_encode(mk(OP_IMM, 3, 4, 0, 6, 0, 32'h0000_0055));
    @(negedge clk);
    idle();
    n_tests++; if (bus0.out_valid !== 1'b1 || bus0.wr_addr !== 32'h0 || bus0.instr_bits !== e3[31:0]) begin
      n_fail++; $display("FAIL r2_first_after got=%b %h@%h exp=1 %h@00000000", bus0.out_valid, bus0.instr_bits, bus0.wr_addr, e3[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        head;
    bundle_t     b;
    logic [32:0] r;
    logic [31:0] next_addr;
    logic        exp_err, v, ordy, rdy, ov;
    int          emits, errs;
    apply_reset();
    next_addr = 32'h0;
    exp_err   = 1'b0;
    emits     = 0;
    errs      = 0;
    for (int c = 0; c < 700; c++) begin
      rdy = bus0.in_ready;
      ov  = bus0.out_valid;
      n_tests++; if (bus0.err !== exp_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, bus0.err, exp_err); end
      n_tests++; if (ov !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, ov, q.size() != 0); end
      n_tests++; if (rdy !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, rdy, q.size() < 2); end
      if (q.size() != 0) begin
        head = q[0];
        n_tests++; if (bus0.instr_bits !== head.bits || bus0.wr_addr !== head.addr) begin
          n_fail++; $display("FAIL rnd_word cyc=%0d got=%h@%h exp=%h@%h", c, bus0.instr_bits, bus0.wr_addr, head.bits, head.addr); end
      end else begin
        n_tests++; if (bus0.instr_bits !== 32'h0) begin n_fail++; $display("FAIL rnd_idle_bits cyc=%0d got=%h exp=0", c, bus0.instr_bits); end
      end
      if (c < 690) begin
        ordy = ($urandom_range(0, 3) != 0);
        v    = ($urandom_range(0, 9) < 7);
      end else begin
        ordy = 1'b1;
        v    = 1'b0;
      end
      b = rand_bundle();
      if (ov && ordy) begin
        void'(q.pop_front());
        emits++;
      end
      exp_err = 1'b0;
      if (v && rdy) begin
        r = ref_encode(b);
        if (r[32]) begin
          head.bits = r[31:0];
          head.addr = next_addr;
          q.push_back(head);
          next_addr = next_addr + 32'd4;
        end else begin
          exp_err = 1'b1;
          errs++;
        end
      end
      bus0.out_ready = ordy;
      drive(v, b);
      @(negedge clk);
    end
    n_tests++; if (bus0.emit_count !== 16'(emits)) begin n_fail++; $display("FAIL rnd_emit_count got=%0d exp=%0d", bus0.emit_count, emits); end
    n_tests++; if (bus0.err_count !== 16'(errs)) begin n_fail++; $display("FAIL rnd_err_count got=%0d exp=%0d", bus0.err_count, errs); end
  endtask

  initial begin
    idle();
    bus0.out_ready = 1'b0;
    test_reset();
    test_addi();
    test_store_lui();
    test_reject();
    test_backpressure();
    test_wrap();
    test_reset_in_two();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the first instruction-memory write address; it SHALL be a multiple of 4.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit; the field bundle is valid.
REQ-005 SHALL have port in_ready, output, 1 bit; the encoder accepts a bundle this cycle.
REQ-006 SHALL have port opcode, input, opcode_t; one of LUI, OP_IMM, OP, LOAD, STORE or UNKNOWN.
REQ-007 SHALL have ports rs1, rs2 and rd, input, rv_reg_t (5 bits); the register fields.
REQ-008 SHALL have ports funct3 (input, 3 bits) and funct7 (input, 7 bits).
REQ-009 SHALL have port imm, input, XLEN (32) bits; the full immediate value, not pre-split.
REQ-010 SHALL have port out_valid, output, 1 bit; instr_bits/wr_addr are valid.
REQ-011 SHALL have port out_ready, input, 1 bit; the instruction-memory writer accepts.
REQ-012 SHALL have port instr_bits, output, ILEN (32) bits; the encoded instruction.
REQ-013 SHALL have port wr_addr, output, XLEN bits; the write address paired with instr_bits.
REQ-014 SHALL have port err, output, 1 bit; a one-cycle pulse when an accepted bundle is rejected.
REQ-015 SHALL have ports emit_count and err_count, output, 16 bits each; saturating counters of emitted and rejected bundles.

Function
REQ-016 SHALL treat a bundle as accepted when in_valid and in_ready are both high, and an output as transferred when out_valid and out_ready are both high.
REQ-017 SHALL encode the opcode field [6:0] as LUI 0110111, OP_IMM 0010011, OP 0110011, LOAD 0000011 and STORE 0100011.
REQ-018 SHALL encode LUI (U-type) as {imm[31:12], rd, opcode}.
REQ-019 SHALL encode OP (R-type) as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-020 SHALL encode LOAD, and OP_IMM with funct3 not 001 or 101, as I-type {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 SHALL encode OP_IMM with funct3 001 or 101 (shifts) as {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-022 SHALL encode STORE (S-type) as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rs2 occupies bits [24:20] in every format that carries it.
REQ-023 SHALL reject a bundle when: opcode is UNKNOWN; an I or S imm has imm[31:11] not all equal; a shift imm has imm[31:5] nonzero; or a LUI imm has imm[11:0] nonzero.
REQ-024 SHALL discard a rejected bundle (no output entry), pulse err the following cycle, and increment err_count.
REQ-025 SHALL have a latency of one cycle: a legal bundle accepted in cycle N is presented with out_valid high in cycle N+1 if the output register is free.
REQ-026 SHALL buffer output in a 2-entry skid (main register plus skid register) with states EMPTY, ONE and TWO:
- EMPTY -> ONE on a legal accept.
- ONE -> TWO on a legal accept without a transfer.
- ONE -> EMPTY on a transfer without a legal accept.
- TWO -> ONE on a transfer; the skid entry moves to main.
- ONE stays ONE on a simultaneous legal accept and transfer.
REQ-027 SHALL drive in_ready = (state != TWO) from registered state only, with no combinational path from out_ready.
REQ-028 SHALL keep instr_bits and wr_addr stable while out_valid is high and out_ready is low.
REQ-029 SHALL assign wr_addr per emitted entry at encode time: the first is BASE_ADDR, each subsequent one +4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); rejected bundles do not consume an address.
REQ-030 SHALL increment emit_count on each transfer; both counters saturate at 16'hFFFF.
REQ-031 SHALL output instr_bits = 0 when out_valid is low.

Reset
REQ-032 SHALL, while reset_n is low, hold state EMPTY, out_valid 0, in_ready 0, err 0, instr_bits 0, both counters 0, and the next address at BASE_ADDR.
REQ-033 SHALL drop buffered entries on reset mid-operation, never emitting them; in_ready goes high in the first cycle after reset_n deasserts.

Verification
REQ-034 Bench SHALL check: ADDI x1,x2,-1 (OP_IMM, f3=000, imm=FFFF_FFFF), out_ready=1 -> next cycle instr_bits 0xFFF1_0093, wr_addr BASE_ADDR.
REQ-035 Bench SHALL check: SW x5,8(x2) (STORE, f3=010, imm=8, rs2=5) then LUI x3,0x12345000 -> 0x0051_2423 at BASE, then 0x1234_51B7 at BASE+4.
REQ-036 Bench SHALL check: OP_IMM imm=0x800 -> err pulses one cycle, err_count=1, no out_valid, and the next legal bundle still gets BASE_ADDR.
REQ-037 Bench SHALL check: out_ready=0 with 3 legal bundles offered -> two accepted, in_ready low, instr_bits stable; then out_ready=1 -> outputs in order at BASE, +4, +8.
REQ-038 Bench SHALL check: BASE_ADDR=0xFFFF_FFF8 with 3 bundles -> wr_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 Bench SHALL check: reset_n asserted in state TWO -> out_valid falls immediately, counters 0, and after release the first output uses BASE_ADDR.
